// File: rtl/bubble_buffer_reader_pkg.sv
// -----------------------------------------------------------------------------
// bubble_buffer_reader_pkg
//
// Shared constants and types for the bubble memory loader and the buffer
// reader that streams 2-bit words out to the bubble write circuitry.
//
// Contents:
//   - Loader geometry: page and bootloader sizes in bytes, and the helper that
//     turns a byte count into a count of 2-bit bubble words.
//   - Default read-out lengths in words (PAGE = 512, BOOT = 1920).
//   - Address width and the parked read address used while idle (0x7FF).
//   - State encoding of the reader FSM.
// -----------------------------------------------------------------------------
package bubble_buffer_reader_pkg;

   // Width of the buffer RAM address and of the word counter.
   localparam int BBR_ADDR_W = 11;

   // Each bubble position carries one 2-bit word (two parallel loops).
   localparam int BBR_WORD_W = 2;

   localparam int BBR_BITS_PER_BYTE = 8;

   // Loader geometry in bytes: a data page and the bootloader image.
   localparam int BBR_PAGE_BYTES = 128;
   localparam int BBR_BOOT_BYTES = 480;

   // While idle the read port is parked on the top address, which no
   // read-out ever reaches, so a stray RAM read cannot alias word 0.
   localparam logic [BBR_ADDR_W-1:0] BBR_IDLE_ADDR = 11'h7FF;

   // Number of 2-bit words needed to carry the given number of bytes.
   function automatic int bytesToWords(input int numBytes);
      return (numBytes * BBR_BITS_PER_BYTE) / BBR_WORD_W;
   endfunction

   // Default read-out lengths in words.
   localparam int BBR_PAGE_WORDS = bytesToWords(BBR_PAGE_BYTES);
   localparam int BBR_BOOT_WORDS = bytesToWords(BBR_BOOT_BYTES);

   // Reader FSM states.
   //   IDLE      : waiting for start, address parked at 0x7FF
   //   FETCH     : address presented to the RAM for one cycle
   //   LATCH     : RAM data captured into the prefetch register
   //   WAIT_TICK : prefetched word ready, waiting for a position tick
   //   FINISH    : last word on the outputs, done pulsed, then back to IDLE
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_FETCH     = 3'd1,
      ST_LATCH     = 3'd2,
      ST_WAIT_TICK = 3'd3,
      ST_FINISH    = 3'd4
   } bbrState_t;

endpackage

// File: rtl/bubble_buffer_reader.sv
// -----------------------------------------------------------------------------
// bubble_buffer_reader
//
// Streams a page (or the bootloader image) out of the buffer RAM one 2-bit
// word per bubble position. Each word is fetched from the synchronous RAM
// ahead of time into a prefetch register; a position tick then moves it onto
// the bubble outputs on the following cycle and the next fetch begins.
//
// Ports:
//   master_clock        in   48 MHz master clock, the only clock
//   n_reset             in   asynchronous active-low reset
//   start               in   one-cycle pulse that begins a read-out (IDLE only)
//   boot_mode           in   sampled on start: 1 = BOOT_WORDS, 0 = PAGE_WORDS
//   abort               in   level; terminates any read-out, beats start/tick
//   position_tick       in   one-cycle pulse per bubble position (>= 4 apart)
//   buffer_read_address out  RAM read address, 0x7FF while idle
//   buffer_read_data    in   RAM read data, valid one cycle after the address
//   bubble_out_d0       out  registered bit 0 of the current word
//   bubble_out_d1       out  registered bit 1 of the current word
//   word_valid          out  one-cycle pulse when bubble_out_d* update
//   busy                out  high whenever the reader is not in IDLE
//   done                out  one-cycle pulse alongside the last word
//   overrun             out  sticky: a tick came before the word was ready
// -----------------------------------------------------------------------------
module bubble_buffer_reader
   import bubble_buffer_reader_pkg::*;
#(
   parameter int PAGE_WORDS = BBR_PAGE_WORDS,
   parameter int BOOT_WORDS = BBR_BOOT_WORDS
) (
   input  logic                  master_clock,
   input  logic                  n_reset,
   input  logic                  start,
   input  logic                  boot_mode,
   input  logic                  abort,
   input  logic                  position_tick,
   output logic [BBR_ADDR_W-1:0] buffer_read_address,
   input  logic [BBR_WORD_W-1:0] buffer_read_data,
   output logic                  bubble_out_d0,
   output logic                  bubble_out_d1,
   output logic                  word_valid,
   output logic                  busy,
   output logic                  done,
   output logic                  overrun
);

   localparam logic [BBR_ADDR_W-1:0] PAGE_LEN = BBR_ADDR_W'(PAGE_WORDS);
   localparam logic [BBR_ADDR_W-1:0] BOOT_LEN = BBR_ADDR_W'(BOOT_WORDS);

   // FSM state
   bbrState_t r_state;
   bbrState_t w_nextState;

   // Datapath registers
   logic [BBR_ADDR_W-1:0] r_length;
   logic [BBR_ADDR_W-1:0] r_address;
   logic [BBR_ADDR_W-1:0] r_count;
   logic [BBR_WORD_W-1:0] r_prefetch;
   logic                  r_d0;
   logic                  r_d1;
   logic                  r_wordValid;
   logic                  r_done;
   logic                  r_overrun;

   // Control strobes decoded by the next-state logic
   logic                  w_load;
   logic                  w_capture;
   logic                  w_present;
   logic                  w_lastWord;
   logic                  w_tickDropped;
   logic                  w_finish;
   logic [BBR_ADDR_W-1:0] w_lastIndex;

   // r_count holds how many words have already been presented, so the word
   // sitting in the prefetch register is the last one when the count has
   // reached length-1.
   assign w_lastIndex = r_length - 11'd1;
   assign w_lastWord  = (r_count == w_lastIndex);

   // State register. Reset parks the reader in IDLE regardless of where a
   // read-out was, which discards it without a done pulse.
   always_ff @(posedge master_clock or negedge n_reset) begin
      if (!n_reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state and strobe decode. Abort is checked before anything else so
   // that a simultaneous start or tick has no effect. A tick that lands while
   // the next word is still being fetched is flagged and thrown away rather
   // than presenting a stale word.
   always_comb begin
      w_nextState   = r_state;
      w_load        = 1'b0;
      w_capture     = 1'b0;
      w_present     = 1'b0;
      w_tickDropped = 1'b0;
      w_finish      = 1'b0;

      if (abort) begin
         w_nextState = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  w_load      = 1'b1;
                  w_nextState = ST_FETCH;
               end
            end

            ST_FETCH: begin
               w_tickDropped = position_tick;
               w_nextState   = ST_LATCH;
            end

            ST_LATCH: begin
               w_tickDropped = position_tick;
               w_capture     = 1'b1;
               w_nextState   = ST_WAIT_TICK;
            end

            ST_WAIT_TICK: begin
               if (position_tick) begin
                  w_present = 1'b1;
                  if (w_lastWord) begin
                     w_nextState = ST_FINISH;
                  end else begin
                     w_nextState = ST_FETCH;
                  end
               end
            end

            ST_FINISH: begin
               w_finish    = 1'b1;
               w_nextState = ST_IDLE;
            end

            default: begin
               w_nextState = ST_IDLE;
            end
         endcase
      end
   end

   // Datapath. The address only advances when another word is still owed,
   // so it stops at length-1 and the 0x7FF wrap can never be reached from a
   // read-out. done is raised together with the last word_valid, which is
   // the cycle the reader sits in FINISH; leaving FINISH clears the outputs
   // and parks the address.
   always_ff @(posedge master_clock or negedge n_reset) begin
      if (!n_reset) begin
         r_length    <= '0;
         r_address   <= BBR_IDLE_ADDR;
         r_count     <= '0;
         r_prefetch  <= '0;
         r_d0        <= 1'b0;
         r_d1        <= 1'b0;
         r_wordValid <= 1'b0;
         r_done      <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_wordValid <= 1'b0;
         r_done      <= 1'b0;

         if (abort) begin
            r_address <= BBR_IDLE_ADDR;
            r_d0      <= 1'b0;
            r_d1      <= 1'b0;
         end else begin
            if (w_load) begin
               r_length  <= boot_mode ? BOOT_LEN : PAGE_LEN;
               r_address <= '0;
               r_count   <= '0;
               r_overrun <= 1'b0;
            end

            if (w_tickDropped) begin
               r_overrun <= 1'b1;
            end

            if (w_capture) begin
               r_prefetch <= buffer_read_data;
            end

            if (w_present) begin
               r_d0        <= r_prefetch[0];
               r_d1        <= r_prefetch[1];
               r_wordValid <= 1'b1;
               r_count     <= r_count + 11'd1;
               if (w_lastWord) begin
                  r_done <= 1'b1;
               end else begin
                  r_address <= r_address + 11'd1;
               end
            end

            if (w_finish) begin
               r_address <= BBR_IDLE_ADDR;
               r_d0      <= 1'b0;
               r_d1      <= 1'b0;
            end
         end
      end
   end

   assign buffer_read_address = r_address;
   assign bubble_out_d0       = r_d0;
   assign bubble_out_d1       = r_d1;
   assign word_valid          = r_wordValid;
   assign done                = r_done;
   assign overrun             = r_overrun;
   assign busy                = (r_state != ST_IDLE);

endmodule

// File: tb/tb_bubble_buffer_reader.sv
// -----------------------------------------------------------------------------
// tb_bubble_buffer_reader
//
// Drives bubble_buffer_reader with page, bootloader, overrun, abort and
// mid-read reset scenarios using randomized tick spacing and RAM contents.
// The reference model works at the level of "which word is owed next and from
// which cycle it is ready": a word is ready three cycles after its fetch
// begins, a tick before then is an overrun, a tick after it yields that word
// on the next cycle, and the last word comes with done.
// -----------------------------------------------------------------------------
module tb_bubble_buffer_reader;

   localparam int PAGE_LEN     = 512;
   localparam int BOOT_LEN     = 1920;
   localparam int IDLE_ADDR    = 'h7FF;
   localparam int CYCLE_BUDGET = 20000;

   logic        masterClock = 1'b0;
   logic        nReset;
   logic        start;
   logic        bootMode;
   logic        abort;
   logic        positionTick;
   logic [10:0] bufferReadAddress;
   logic [1:0]  bufferReadData;
   logic        bubbleOutD0;
   logic        bubbleOutD1;
   logic        wordValid;
   logic        busy;
   logic        done;
   logic        overrun;

   // Buffer RAM with a synchronous read port
   logic [1:0]  mem [0:2047];

   int assertCount = 0;
   int failCount   = 0;
   int cyc         = 0;

   // Reference model state
   bit         mBusy;
   bit         mFinishing;
   bit         mOverrun;
   bit         mJustStarted;
   bit         expWv;
   bit         expDone;
   logic [1:0] expD;
   int         mLen;
   int         mIdx;
   int         mReadyAt;

   // Observations collected per read-out
   int dutWords;
   int dutDones;
   int maxAddr;

   bubble_buffer_reader dut (
      .master_clock        (masterClock),
      .n_reset             (nReset),
      .start               (start),
      .boot_mode           (bootMode),
      .abort               (abort),
      .position_tick       (positionTick),
      .buffer_read_address (bufferReadAddress),
      .buffer_read_data    (bufferReadData),
      .bubble_out_d0       (bubbleOutD0),
      .bubble_out_d1       (bubbleOutD1),
      .word_valid          (wordValid),
      .busy                (busy),
      .done                (done),
      .overrun             (overrun)
   );

   always #5 masterClock = ~masterClock;

   always @(posedge masterClock) begin
      bufferReadData <= mem[bufferReadAddress];
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                  tag, observed, expected, cyc);
      end
   endtask

   // Advance the model across one clock edge given the inputs held during
   // cycle k.
   task automatic modelEdge(input bit st, input bit bm, input bit tk,
                            input bit ab, input int k);
      expWv        = 1'b0;
      expDone      = 1'b0;
      mJustStarted = 1'b0;
      if (ab) begin
         mBusy      = 1'b0;
         mFinishing = 1'b0;
         expD       = 2'b00;
      end else if (mFinishing) begin
         mBusy      = 1'b0;
         mFinishing = 1'b0;
         expD       = 2'b00;
      end else if (!mBusy) begin
         if (st) begin
            mBusy        = 1'b1;
            mLen         = bm ? BOOT_LEN : PAGE_LEN;
            mIdx         = 0;
            mOverrun     = 1'b0;
            mReadyAt     = k + 3;
            mJustStarted = 1'b1;
         end
      end else if (tk) begin
         if (k < mReadyAt) begin
            mOverrun = 1'b1;
         end else begin
            expWv = 1'b1;
            expD  = mem[mIdx];
            mIdx++;
            if (mIdx == mLen) begin
               expDone    = 1'b1;
               mFinishing = 1'b1;
            end else begin
               mReadyAt = k + 3;
            end
         end
      end
   endtask

   task automatic modelReset();
      mBusy        = 1'b0;
      mFinishing   = 1'b0;
      mOverrun     = 1'b0;
      mJustStarted = 1'b0;
      expWv        = 1'b0;
      expDone      = 1'b0;
      expD         = 2'b00;
   endtask

   task automatic checkCycle();
      checkOutput("word_valid", wordValid, expWv);
      checkOutput("bubble_out", {bubbleOutD1, bubbleOutD0}, expD);
      checkOutput("done", done, expDone);
      checkOutput("busy", busy, mBusy);
      checkOutput("overrun", overrun, mOverrun);
      if (!mBusy) begin
         checkOutput("idleAddr", bufferReadAddress, IDLE_ADDR);
      end else if (mJustStarted) begin
         checkOutput("startAddr", bufferReadAddress, 0);
      end
      if (mBusy && int'(bufferReadAddress) > maxAddr) begin
         maxAddr = int'(bufferReadAddress);
      end
      if (wordValid === 1'b1) dutWords++;
      if (done === 1'b1) dutDones++;
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_out"}, {bubbleOutD1, bubbleOutD0}, 0);
      checkOutput({tag, "_valid"}, wordValid, 0);
      checkOutput({tag, "_busy"}, busy, 0);
      checkOutput({tag, "_done"}, done, 0);
      checkOutput({tag, "_overrun"}, overrun, 0);
      checkOutput({tag, "_addr"}, bufferReadAddress, IDLE_ADDR);
   endtask

   // Called at a falling edge: inputs are held through the next rising edge,
   // the model advances, and outputs are compared at the following falling
   // edge.
   task automatic applyStimulus(input bit st, input bit bm, input bit tk,
                                input bit ab);
      start        = st;
      bootMode     = bm;
      positionTick = tk;
      abort        = ab;
      @(posedge masterClock);
      modelEdge(st, bm, tk, ab, cyc);
      cyc++;
      @(negedge masterClock);
      checkCycle();
   endtask

   // Reset pulse placed entirely between clock edges.
   task automatic asyncReset();
      start        = 1'b0;
      positionTick = 1'b0;
      abort        = 1'b0;
      nReset       = 1'b0;
      #1;
      checkResetState("asyncReset");
      #1;
      nReset = 1'b1;
      modelReset();
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b0, 1'($urandom_range(1, 0)),
                       1'($urandom_range(1, 0)), 1'b0);
      end
   endtask

   // One read-out: start, then ticks spaced firstGap and then minGap..maxGap
   // cycles apart. stopAtWord >= 0 aborts (or resets) once that many words
   // have been presented; busyNoise sprinkles start pulses during the read.
   task automatic runRead(input bit bm, input int firstGap, input int minGap,
                          input int maxGap, input int stopAtWord,
                          input bit useReset, input bit busyNoise);
      int gapCnt;
      int curGap;
      int budget;
      bit tk;
      bit st;
      bit ab;
      bit nbm;
      dutWords = 0;
      dutDones = 0;
      maxAddr  = 0;
      applyStimulus(1'b1, bm, 1'b0, 1'b0);
      gapCnt = 0;
      curGap = firstGap;
      budget = 0;
      while (mBusy && budget < CYCLE_BUDGET) begin
         budget++;
         gapCnt++;
         tk  = (gapCnt >= curGap);
         ab  = 1'b0;
         st  = 1'b0;
         nbm = bm;
         if (stopAtWord >= 0 && mIdx == stopAtWord && !mFinishing) begin
            if (useReset) begin
               asyncReset();
               break;
            end
            ab = 1'b1;
         end
         if (tk) begin
            gapCnt = 0;
            curGap = $urandom_range(maxGap, minGap);
         end
         if (busyNoise && !tk && $urandom_range(15, 0) == 0) begin
            st  = 1'b1;
            nbm = 1'($urandom_range(1, 0));
         end
         applyStimulus(st, nbm, tk, ab);
      end
      if (budget >= CYCLE_BUDGET) begin
         checkOutput("cycleBudget", budget, CYCLE_BUDGET - 1);
      end
   endtask

   initial begin
      nReset       = 1'b0;
      start        = 1'b0;
      bootMode     = 1'b0;
      abort        = 1'b0;
      positionTick = 1'b0;
      mLen         = 0;
      mIdx         = 0;
      mReadyAt     = 0;
      modelReset();
      for (int i = 0; i < 2048; i++) mem[i] = 2'(i);

      #12;
      checkResetState("reset");
      @(negedge masterClock);
      nReset = 1'b1;

      $display("[TB] ticks while idle");
      idleCycles(12);

      $display("[TB] page read, addr[1:0] pattern, ticks every 8");
      runRead(1'b0, 8, 8, 8, -1, 1'b0, 1'b0);
      checkOutput("pageWords", dutWords, PAGE_LEN);
      checkOutput("pageDone", dutDones, 1);
      checkOutput("pageMaxAddr", maxAddr, PAGE_LEN - 1);
      idleCycles(6);

      for (int i = 0; i < 2048; i++) mem[i] = 2'($urandom_range(3, 0));

      $display("[TB] bootloader read, ticks every 4");
      runRead(1'b1, 3, 4, 4, -1, 1'b0, 1'b0);
      checkOutput("bootWords", dutWords, BOOT_LEN);
      checkOutput("bootDone", dutDones, 1);
      checkOutput("bootOverrun", overrun, 0);
      checkOutput("bootMaxAddr", maxAddr, BOOT_LEN - 1);
      idleCycles(6);

      $display("[TB] overrun: tick one cycle after start");
      runRead(1'b0, 1, 4, 7, -1, 1'b0, 1'b1);
      checkOutput("overrunWords", dutWords, PAGE_LEN);
      checkOutput("overrunDone", dutDones, 1);
      checkOutput("overrunSticky", overrun, 1);
      idleCycles(8);
      checkOutput("overrunStillSticky", overrun, 1);

      $display("[TB] abort at word 100");
      runRead(1'b0, 3, 4, 9, 100, 1'b0, 1'b1);
      checkOutput("abortWords", dutWords, 100);
      checkOutput("abortDone", dutDones, 0);
      checkOutput("abortBusy", busy, 0);
      checkOutput("abortAddr", bufferReadAddress, IDLE_ADDR);
      idleCycles(6);

      $display("[TB] async reset at word 300");
      runRead(1'b0, 3, 4, 8, 300, 1'b1, 1'b0);
      checkOutput("resetWords", dutWords, 300);
      checkOutput("resetDone", dutDones, 0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("resetIdle", busy, 0);

      $display("[TB] fresh page read after reset, starts while busy");
      for (int i = 0; i < 2048; i++) mem[i] = 2'($urandom_range(3, 0));
      runRead(1'b0, 4, 4, 6, -1, 1'b0, 1'b1);
      checkOutput("freshWords", dutWords, PAGE_LEN);
      checkOutput("freshDone", dutDones, 1);
      checkOutput("freshMaxAddr", maxAddr, PAGE_LEN - 1);
      idleCycles(10);

      $display("End of test - %0d assertions evaluated, %0d failures",
               assertCount, failCount);
      $finish;
   end

endmodule
